// File: rtl/rob_commit_queue.sv
// ============================================================================
// Module   : rob_commit_queue
// Purpose  : Circular reorder buffer that retires results in program order
//            and raises a one-cycle flush on a mispredicted head branch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_branch,
  input  logic             issue_pred_taken,
  input  logic [31:0]      issue_pc,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  input  logic [TAG_W-1:0] q_tag,
  output logic             q_ready,
  output logic [31:0]      q_value,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0]   c_full    = DEPTH[TAG_W:0];
  localparam logic [TAG_W:0]   c_cnt_one = 1;
  localparam logic [TAG_W-1:0] c_tag_one = 1;
  localparam logic [31:0]      c_pc_step = 32'd4;

  // Control state: pointers, occupancy and per-entry status flags
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_done;

  // Entry payload (no reset needed; qualified by busy/done)
  logic [DEPTH-1:0] r_is_br;
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_taken;
  logic [4:0]       r_rd     [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_value  [DEPTH];
  logic [31:0]      r_target [DEPTH];

  // Registered outputs
  logic             r_commit_valid;
  logic [TAG_W-1:0] r_commit_tag;
  logic [4:0]       r_commit_rd;
  logic [31:0]      r_commit_value;
  logic             r_flush;
  logic [31:0]      r_flush_pc;

  logic w_alloc;
  logic w_wb;
  logic w_commit;
  logic w_mispred;

  assign issue_ready = (r_count != c_full) && !r_flush;
  assign issue_tag   = r_tail;

  assign w_alloc   = rdy && issue_valid && issue_ready;
  assign w_wb      = rdy && wb_valid && r_busy[wb_tag];
  assign w_commit  = rdy && r_busy[r_head] && r_done[r_head];
  assign w_mispred = w_commit && r_is_br[r_head] && (r_taken[r_head] != r_pred[r_head]);

  assign q_ready = r_busy[q_tag] && r_done[q_tag];
  assign q_value = r_value[q_tag];

  assign commit_valid = r_commit_valid;
  assign commit_tag   = r_commit_tag;
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign flush        = r_flush;
  assign flush_pc     = r_flush_pc;
  assign count        = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_done         <= '0;
      r_commit_valid <= 1'b0;
      r_commit_tag   <= '0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
    end else if (!rdy) begin
      r_commit_valid <= 1'b0;
      r_flush        <= 1'b0;
    end else begin
      r_commit_valid <= w_commit;
      r_flush        <= w_mispred;
      if (w_commit) begin
        r_commit_tag   <= r_head;
        r_commit_rd    <= r_rd[r_head];
        r_commit_value <= r_value[r_head];
      end
      if (w_mispred) begin
        // A flush wipes the whole window, including any same-edge alloc/writeback
        r_flush_pc <= r_taken[r_head] ? r_target[r_head] : (r_pc[r_head] + c_pc_step);
        r_busy     <= '0;
        r_done     <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_wb) begin
          r_done[wb_tag] <= 1'b1;
        end
        if (w_alloc) begin
          r_busy[r_tail] <= 1'b1;
          r_done[r_tail] <= 1'b0;
          r_tail         <= r_tail + c_tag_one;
        end
        // Retire last so it wins over a repeated writeback to the head
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_done[r_head] <= 1'b0;
          r_head         <= r_head + c_tag_one;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (w_alloc) begin
        r_rd[r_tail]    <= issue_rd;
        r_pc[r_tail]    <= issue_pc;
        r_is_br[r_tail] <= issue_is_branch;
        r_pred[r_tail]  <= issue_pred_taken;
      end
      if (w_wb) begin
        r_value[wb_tag]  <= wb_value;
        r_taken[wb_tag]  <= wb_taken;
        r_target[wb_tag] <= wb_target;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_queue.sv
// ============================================================================
// Module   : tb_rob_commit_queue
// Purpose  : Directed self-checking bench for rob_commit_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_commit_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_is_branch = 1'b0;
  logic        issue_pred_taken = 1'b0;
  logic [31:0] issue_pc = '0;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        wb_taken = 1'b0;
  logic [31:0] wb_target = '0;
  logic [3:0]  q_tag = '0;
  logic        q_ready;
  logic [31:0] q_value;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  rob_commit_queue #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
    .issue_pc(issue_pc), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_commit(input string tag, input logic [3:0] t, input logic [4:0] rd,
                            input logic [31:0] v);
    chk({tag, "_valid"}, 32'(commit_valid), 32'd1);
    chk({tag, "_tag"},   32'(commit_tag),   32'(t));
    chk({tag, "_rd"},    32'(commit_rd),    32'(rd));
    chk({tag, "_value"}, commit_value,      v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_issue_tag", 32'(issue_tag), 32'd0);
    rst = 1'b0;

    // ---------------- in-order retire with out-of-order writeback
    issue_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue_rd = 5'(i);
      issue_pc = 32'h1000 + 32'(4 * i);
      tick();
    end
    issue_valid = 1'b0;
    chk("t1_count3", 32'(count), 32'd3);
    chk("t1_issue_tag", 32'(issue_tag), 32'd3);
    q_tag = 4'd0;
    #1;
    chk("t1_q0_not_ready", 32'(q_ready), 32'd0);

    wb_valid = 1'b1; wb_tag = 4'd2; wb_value = 32'h22;
    tick();
    chk("t1_no_commit_a", 32'(commit_valid), 32'd0);
    q_tag = 4'd2;
    #1;
    chk("t1_q2_ready", 32'(q_ready), 32'd1);
    chk("t1_q2_value", q_value, 32'h22);

    wb_tag = 4'd0; wb_value = 32'h00;
    tick();
    chk("t1_no_commit_b", 32'(commit_valid), 32'd0);

    wb_tag = 4'd1; wb_value = 32'h11;
    tick();
    wb_valid = 1'b0;
    chk_commit("t1_c0", 4'd0, 5'd1, 32'h00);
    tick();
    chk_commit("t1_c1", 4'd1, 5'd2, 32'h11);
    tick();
    chk_commit("t1_c2", 4'd2, 5'd3, 32'h22);
    chk("t1_count0", 32'(count), 32'd0);
    tick();
    chk("t1_idle", 32'(commit_valid), 32'd0);

    // ---------------- fill to 16, overflow ignored, wrap
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_pc = 32'h2000;
    for (int i = 0; i < 16; i++) tick();
    chk("t2_count16", 32'(count), 32'd16);
    chk("t2_not_ready", 32'(issue_ready), 32'd0);
    chk("t2_tail_wrapped", 32'(issue_tag), 32'd0);
    issue_rd = 5'd31;
    tick();
    issue_valid = 1'b0;
    chk("t2_overflow_count", 32'(count), 32'd16);

    wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'hAA;
    tick();
    wb_valid = 1'b0;
    chk("t2_no_commit_yet", 32'(commit_valid), 32'd0);
    tick();
    chk_commit("t2_c0", 4'd0, 5'd5, 32'hAA);
    chk("t2_count15", 32'(count), 32'd15);
    chk("t2_ready_again", 32'(issue_ready), 32'd1);
    chk("t2_wrap_tag", 32'(issue_tag), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    chk("t2_refill_count", 32'(count), 32'd16);
    chk("t2_refill_tag", 32'(issue_tag), 32'd1);

    // ---------------- mispredict: predicted not-taken, actually taken
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_is_branch = 1'b1;
    issue_pred_taken = 1'b0; issue_pc = 32'h100;
    tick();
    issue_is_branch = 1'b0; issue_rd = 5'd4;
    for (int i = 0; i < 4; i++) tick();
    issue_valid = 1'b0;
    chk("t3_count5", 32'(count), 32'd5);
    wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h0; wb_taken = 1'b1; wb_target = 32'h200;
    tick();
    // Same-edge allocation and writeback must both be discarded by the flush
    issue_valid = 1'b1; issue_rd = 5'd7;
    wb_tag = 4'd1; wb_value = 32'h55; wb_taken = 1'b0;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    chk("t3_flush", 32'(flush), 32'd1);
    chk("t3_commit_valid", 32'(commit_valid), 32'd1);
    chk("t3_flush_pc", flush_pc, 32'h200);
    chk("t3_count0", 32'(count), 32'd0);
    chk("t3_issue_tag0", 32'(issue_tag), 32'd0);
    chk("t3_ready_low", 32'(issue_ready), 32'd0);
    q_tag = 4'd1;
    #1;
    chk("t3_wb_discarded", 32'(q_ready), 32'd0);
    tick();
    chk("t3_flush_pulse", 32'(flush), 32'd0);
    chk("t3_ready_back", 32'(issue_ready), 32'd1);

    // ---------------- mispredict: predicted taken, fall-through wraps
    issue_valid = 1'b1; issue_is_branch = 1'b1; issue_pred_taken = 1'b1;
    issue_pc = 32'hFFFF_FFFC; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd0; wb_taken = 1'b0; wb_target = 32'h1234;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_flush_pc_wrap", flush_pc, 32'h0);
    tick();

    // ---------------- rdy freeze
    issue_valid = 1'b1; issue_rd = 5'd9; issue_pc = 32'h300;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h99;
    tick();
    wb_valid = 1'b0;
    rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_frozen_commit", 32'(commit_valid), 32'd0);
      chk("t5_frozen_count", 32'(count), 32'd1);
    end
    issue_valid = 1'b0; rdy = 1'b1;
    tick();
    chk_commit("t5_c0", 4'd0, 5'd9, 32'h99);
    chk("t5_count0", 32'(count), 32'd0);

    // ---------------- async reset during a commit pulse
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd1; wb_value = 32'h77;
    tick();
    wb_valid = 1'b0;
    tick();
    chk_commit("t6_c1", 4'd1, 5'd12, 32'h77);
    chk("t6_count1", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_commit", 32'(commit_valid), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_tag", 32'(issue_tag), 32'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
